// File: rtl/tetris_game_seq.sv
// Game-step sequencer: orders board clear, spawn, collision checks,
// erase/draw, lock and line clear through req/done handshakes, and tracks
// player moves, gravity, line/level bookkeeping and game over.
//
// state      | meaning
// IDLE       | waiting for a go release
// CLEAR      | board clear handshake; zeroes score/level/game_over
// SPAWN      | load a new piece from the LFSR into the candidate
// SPAWN_CHK  | collision check of the freshly spawned piece
// DRAW       | paint the candidate; commit it as the current piece
// WAIT       | gravity counting and move sampling
// CHECK      | collision check of a moved candidate
// ERASE      | erase the current piece before redrawing it
// LOCK       | write the current piece into the board
// LINES      | line clear, score and level update
// OVER       | game over, waiting for a go release
module tetris_game_seq #(
  parameter int          COLS        = 10,
  parameter int          ROWS        = 20,
  parameter int          XW          = 5,
  parameter int          YW          = 6,
  parameter int          SPAWN_X     = 4,
  parameter int          TICK_CYCLES = 25000000,
  parameter int          TICK_DEC    = 2000000,
  parameter int          MIN_TICK    = 2500000,
  parameter int          LEVEL_LINES = 10,
  parameter logic [7:0]  LFSR_SEED   = 8'h01
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          go,
  input  logic          mv_left,
  input  logic          mv_right,
  input  logic          mv_rot,
  input  logic          mv_drop,
  output logic          clear_req,
  input  logic          clear_done,
  output logic          col_req,
  input  logic          col_done,
  input  logic          col_hit,
  output logic          lock_req,
  input  logic          lock_done,
  output logic          line_req,
  input  logic          line_done,
  input  logic [2:0]    lines_cleared,
  output logic          draw_req,
  input  logic          draw_done,
  output logic          draw_clear,
  output logic [XW-1:0] cand_x,
  output logic [YW-1:0] cand_y,
  output logic [2:0]    cand_piece,
  output logic [1:0]    cand_rot,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y,
  output logic [2:0]    cur_piece,
  output logic [1:0]    cur_rot,
  output logic [15:0]   lines_total,
  output logic [3:0]    level,
  output logic          game_over
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_SPAWN, S_SPAWN_CHK, S_DRAW, S_WAIT,
    S_CHECK, S_ERASE, S_LOCK, S_LINES, S_OVER
  } state_t;

  localparam logic [31:0] P_TICK = 32'(TICK_CYCLES);
  localparam logic [31:0] P_DEC  = 32'(TICK_DEC);
  localparam logic [31:0] P_MIN  = 32'(MIN_TICK);

  state_t          r_state, w_next;
  logic            r_go_q, r_down, r_draw_hold, r_game_over;
  logic [7:0]      r_lfsr, r_lvl_cnt;
  logic [XW-1:0]   r_cx, r_ux;
  logic [YW-1:0]   r_cy, r_uy;
  logic [2:0]      r_cp, r_up;
  logic [1:0]      r_cr, r_ur;
  logic [31:0]     r_grav;
  logic [15:0]     r_lines_total;
  logic [3:0]      r_level;

  logic            w_go_fall, w_at_cur, w_tick, w_down_ev, w_at_floor;
  logic            w_clear_ack, w_col_ack, w_draw_ack, w_lock_ack, w_line_ack;
  logic            w_left_ok, w_right_ok;
  logic [2:0]      w_spawn_piece;
  logic [31:0]     w_dec, w_period;
  logic [16:0]     w_lt_sum;
  logic [7:0]      w_lvl_sum;

  assign w_go_fall     = r_go_q & ~go;
  assign w_spawn_piece = (r_lfsr[2:0] == 3'd7) ? 3'd3 : r_lfsr[2:0];

  // Requests follow the state; the hold flag forces a low cycle between
  // the erase and redraw handshakes that share draw_req.
  assign clear_req  = (r_state == S_CLEAR);
  assign col_req    = (r_state == S_SPAWN_CHK) || (r_state == S_CHECK);
  assign lock_req   = (r_state == S_LOCK);
  assign line_req   = (r_state == S_LINES);
  assign draw_req   = ((r_state == S_DRAW) && !r_draw_hold) || (r_state == S_ERASE);
  assign draw_clear = (r_state == S_ERASE);

  assign w_clear_ack = clear_req & clear_done;
  assign w_col_ack   = col_req & col_done;
  assign w_draw_ack  = draw_req & draw_done;
  assign w_lock_ack  = lock_req & lock_done;
  assign w_line_ack  = line_req & line_done;

  // Erase and lock operate on the committed piece, not the pending move.
  assign w_at_cur   = (r_state == S_ERASE) || (r_state == S_LOCK);
  assign cand_x     = w_at_cur ? r_ux : r_cx;
  assign cand_y     = w_at_cur ? r_uy : r_cy;
  assign cand_piece = w_at_cur ? r_up : r_cp;
  assign cand_rot   = w_at_cur ? r_ur : r_cr;

  assign cur_x       = r_ux;
  assign cur_y       = r_uy;
  assign cur_piece   = r_up;
  assign cur_rot     = r_ur;
  assign lines_total = r_lines_total;
  assign level       = r_level;
  assign game_over   = r_game_over;

  assign w_dec    = {28'd0, r_level} * P_DEC;
  assign w_period = ((w_dec >= P_TICK) || ((P_TICK - w_dec) < P_MIN)) ? P_MIN : (P_TICK - w_dec);
  assign w_tick   = (r_grav >= (w_period - 32'd1));

  assign w_down_ev  = w_tick | mv_drop;
  // An anchor on the last row cannot descend; lock without asking.
  assign w_at_floor = (r_uy >= YW'(ROWS - 1));
  assign w_left_ok  = (r_ux != '0);
  assign w_right_ok = (r_ux != XW'(COLS - 1));

  assign w_lt_sum  = {1'b0, r_lines_total} + {14'd0, lines_cleared};
  assign w_lvl_sum = r_lvl_cnt + {5'd0, lines_cleared};

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_go_fall) w_next = S_CLEAR;
      S_CLEAR:     if (w_clear_ack) w_next = S_SPAWN;
      S_SPAWN:     w_next = S_SPAWN_CHK;
      S_SPAWN_CHK: if (w_col_ack) w_next = col_hit ? S_OVER : S_DRAW;
      S_DRAW:      if (w_draw_ack) w_next = S_WAIT;
      S_WAIT: begin
        if (w_down_ev)                w_next = w_at_floor ? S_LOCK : S_CHECK;
        else if (mv_rot)              w_next = S_CHECK;
        else if (mv_left)             w_next = w_left_ok ? S_CHECK : S_WAIT;
        else if (mv_right)            w_next = w_right_ok ? S_CHECK : S_WAIT;
      end
      S_CHECK: begin
        if (w_col_ack) begin
          if (!col_hit)     w_next = S_ERASE;
          else if (r_down)  w_next = S_LOCK;
          else              w_next = S_WAIT;
        end
      end
      S_ERASE:     if (w_draw_ack) w_next = S_DRAW;
      S_LOCK:      if (w_lock_ack) w_next = S_LINES;
      S_LINES:     if (w_line_ack) w_next = S_SPAWN;
      S_OVER:      if (w_go_fall) w_next = S_CLEAR;
      default:     w_next = S_IDLE;
    endcase
  end

  // Datapath: piece registers, gravity, score, level, LFSR.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_go_q        <= 1'b0;
      r_lfsr        <= LFSR_SEED;
      r_draw_hold   <= 1'b0;
      r_down        <= 1'b0;
      r_game_over   <= 1'b0;
      r_cx <= '0; r_cy <= '0; r_cp <= '0; r_cr <= '0;
      r_ux <= '0; r_uy <= '0; r_up <= '0; r_ur <= '0;
      r_grav        <= '0;
      r_lines_total <= '0;
      r_level       <= '0;
      r_lvl_cnt     <= '0;
    end else begin
      r_go_q      <= go;
      r_lfsr      <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      r_draw_hold <= (r_state == S_ERASE) && w_draw_ack;
      case (r_state)
        S_CLEAR: begin
          r_lines_total <= '0;
          r_level       <= '0;
          r_lvl_cnt     <= '0;
          r_game_over   <= 1'b0;
        end
        S_SPAWN: begin
          r_cx   <= XW'(SPAWN_X);
          r_cy   <= '0;
          r_cp   <= w_spawn_piece;
          r_cr   <= '0;
          r_down <= 1'b1;
        end
        S_SPAWN_CHK: if (w_col_ack && col_hit) r_game_over <= 1'b1;
        S_DRAW: begin
          if (w_draw_ack) begin
            r_ux <= r_cx; r_uy <= r_cy; r_up <= r_cp; r_ur <= r_cr;
            if (r_down) r_grav <= '0;
          end
        end
        S_WAIT: begin
          r_grav <= r_grav + 32'd1;
          if (w_down_ev) begin
            r_cy   <= r_uy + YW'(1);
            r_down <= 1'b1;
          end else if (mv_rot) begin
            r_cr   <= r_ur + 2'd1;
            r_down <= 1'b0;
          end else if (mv_left) begin
            if (w_left_ok) begin
              r_cx   <= r_ux - XW'(1);
              r_down <= 1'b0;
            end
          end else if (mv_right) begin
            if (w_right_ok) begin
              r_cx   <= r_ux + XW'(1);
              r_down <= 1'b0;
            end
          end
        end
        S_CHECK: begin
          if (w_col_ack && col_hit && !r_down) begin
            r_cx <= r_ux; r_cy <= r_uy; r_cp <= r_up; r_cr <= r_ur;
          end
        end
        S_LINES: begin
          if (w_line_ack) begin
            r_lines_total <= w_lt_sum[16] ? 16'hFFFF : w_lt_sum[15:0];
            if (w_lvl_sum >= 8'(LEVEL_LINES)) begin
              r_lvl_cnt <= w_lvl_sum - 8'(LEVEL_LINES);
              if (r_level != 4'd15) r_level <= r_level + 4'd1;
            end else begin
              r_lvl_cnt <= w_lvl_sum;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tetris_game_seq.sv
// Directed bench for tetris_game_seq with a short gravity period.
module tb_tetris_game_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       go = 1'b0;
  logic       mv_left = 1'b0, mv_right = 1'b0, mv_rot = 1'b0, mv_drop = 1'b0;
  logic       clear_req, col_req, lock_req, line_req, draw_req, draw_clear;
  logic       clear_done = 1'b0, col_done = 1'b0, col_hit = 1'b0;
  logic       lock_done = 1'b0, line_done = 1'b0, draw_done = 1'b0;
  logic [2:0] lines_cleared = 3'd0;
  logic [4:0] cand_x, cur_x;
  logic [5:0] cand_y, cur_y;
  logic [2:0] cand_piece, cur_piece;
  logic [1:0] cand_rot, cur_rot;
  logic [15:0] lines_total;
  logic [3:0] level;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  tetris_game_seq #(
    .COLS(10), .ROWS(20), .XW(5), .YW(6), .SPAWN_X(4),
    .TICK_CYCLES(20), .TICK_DEC(5), .MIN_TICK(8), .LEVEL_LINES(10),
    .LFSR_SEED(8'h01)
  ) dut (
    .clk(clk), .reset_n(reset_n), .go(go),
    .mv_left(mv_left), .mv_right(mv_right), .mv_rot(mv_rot), .mv_drop(mv_drop),
    .clear_req(clear_req), .clear_done(clear_done),
    .col_req(col_req), .col_done(col_done), .col_hit(col_hit),
    .lock_req(lock_req), .lock_done(lock_done),
    .line_req(line_req), .line_done(line_done), .lines_cleared(lines_cleared),
    .draw_req(draw_req), .draw_done(draw_done), .draw_clear(draw_clear),
    .cand_x(cand_x), .cand_y(cand_y), .cand_piece(cand_piece), .cand_rot(cand_rot),
    .cur_x(cur_x), .cur_y(cur_y), .cur_piece(cur_piece), .cur_rot(cur_rot),
    .lines_total(lines_total), .level(level), .game_over(game_over)
  );

  always #5 clk = ~clk;

  localparam int W_CLEAR = 0, W_COL = 1, W_DRAW = 2, W_LOCK = 3, W_LINE = 4;

  function automatic logic req_of(input int which);
    case (which)
      W_CLEAR: return clear_req;
      W_COL:   return col_req;
      W_DRAW:  return draw_req;
      W_LOCK:  return lock_req;
      default: return line_req;
    endcase
  endfunction

  // Advance on falling edges until the given request is high or the budget runs out.
  task automatic wait_req(input int which, input int maxc, output bit found, output int cycles);
    cycles = 0;
    while (!req_of(which) && cycles < maxc) begin
      @(negedge clk);
      cycles++;
    end
    found = req_of(which);
  endtask

  // One-cycle done pulse with its side data.
  task automatic pulse_done(input int which, input logic hit, input logic [2:0] lc);
    case (which)
      W_CLEAR: clear_done = 1'b1;
      W_COL:   begin col_done = 1'b1; col_hit = hit; end
      W_DRAW:  draw_done = 1'b1;
      W_LOCK:  lock_done = 1'b1;
      default: begin line_done = 1'b1; lines_cleared = lc; end
    endcase
    @(negedge clk);
    clear_done = 1'b0; col_done = 1'b0; col_hit = 1'b0;
    draw_done = 1'b0; lock_done = 1'b0; line_done = 1'b0; lines_cleared = 3'd0;
  endtask

  function automatic logic any_req();
    return clear_req | col_req | draw_req | lock_req | line_req;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (any_req() !== 1'b0) begin errors++; $display("FAIL reset_reqs got %b exp 0", any_req()); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (lines_total !== 16'd0) begin errors++; $display("FAIL reset_lines got %0d exp 0", lines_total); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_over got %b exp 0", game_over); end
    checks++; if ({cur_x, cur_y, cur_piece, cur_rot} !== 16'd0) begin errors++; $display("FAIL reset_cur got %h exp 0", {cur_x, cur_y, cur_piece, cur_rot}); end
  endtask

  task automatic test_start();
    bit found; int cyc; logic [2:0] piece;
    go = 1'b1;
    repeat (3) @(negedge clk);
    go = 1'b0;
    wait_req(W_CLEAR, 10, found, cyc);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL start_clear_req got 0 exp 1"); end
    repeat (5) @(negedge clk);
    checks++; if (clear_req !== 1'b1) begin errors++; $display("FAIL clear_held got %b exp 1", clear_req); end
    pulse_done(W_CLEAR, 1'b0, 3'd0);
    wait_req(W_COL, 10, found, cyc);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL spawn_col_req got 0 exp 1"); end
    checks++; if ({cand_x, cand_y, cand_rot} !== {5'd4, 6'd0, 2'd0}) begin errors++; $display("FAIL spawn_cand got x%0d y%0d r%0d exp x4 y0 r0", cand_x, cand_y, cand_rot); end
    checks++; if (cand_piece > 3'd6) begin errors++; $display("FAIL spawn_piece got %0d exp 0..6", cand_piece); end
    piece = cand_piece;
    pulse_done(W_COL, 1'b0, 3'd0);
    wait_req(W_DRAW, 10, found, cyc);
    checks++; if ({found, draw_clear} !== 2'b10) begin errors++; $display("FAIL spawn_draw got req%b clr%b exp req1 clr0", found, draw_clear); end
    pulse_done(W_DRAW, 1'b0, 3'd0);
    checks++; if ({cur_x, cur_y, cur_piece} !== {5'd4, 6'd0, piece}) begin errors++; $display("FAIL spawn_cur got x%0d y%0d p%0d exp x4 y0 p%0d", cur_x, cur_y, cur_piece, piece); end
  endtask

  // Called right at WAIT entry after the spawn draw.
  task automatic test_gravity();
    bit found; int cyc;
    wait_req(W_COL, 60, found, cyc);
    checks++; if (!found || cyc != 20) begin errors++; $display("FAIL tick_latency got %0d exp 20", cyc); end
    checks++; if ({cand_x, cand_y} !== {5'd4, 6'd1}) begin errors++; $display("FAIL tick_cand got x%0d y%0d exp x4 y1", cand_x, cand_y); end
    pulse_done(W_COL, 1'b0, 3'd0);
    wait_req(W_DRAW, 10, found, cyc);
    checks++; if ({found, draw_clear, cand_y} !== {1'b1, 1'b1, 6'd0}) begin errors++; $display("FAIL erase got req%b clr%b y%0d exp req1 clr1 y0", found, draw_clear, cand_y); end
    pulse_done(W_DRAW, 1'b0, 3'd0);
    checks++; if (draw_req !== 1'b0) begin errors++; $display("FAIL req_gap got %b exp 0", draw_req); end
    wait_req(W_DRAW, 10, found, cyc);
    checks++; if ({found, draw_clear, cand_y} !== {1'b1, 1'b0, 6'd1}) begin errors++; $display("FAIL redraw got req%b clr%b y%0d exp req1 clr0 y1", found, draw_clear, cand_y); end
    pulse_done(W_DRAW, 1'b0, 3'd0);
    checks++; if (cur_y !== 6'd1) begin errors++; $display("FAIL tick_cur_y got %0d exp 1", cur_y); end
  endtask

  task automatic test_moves();
    bit found; int cyc; int seen;
    for (int i = 0; i < 4; i++) begin
      mv_left = 1'b1; @(negedge clk); mv_left = 1'b0;
      wait_req(W_COL, 5, found, cyc); pulse_done(W_COL, 1'b0, 3'd0);
      wait_req(W_DRAW, 5, found, cyc); pulse_done(W_DRAW, 1'b0, 3'd0);
      wait_req(W_DRAW, 5, found, cyc); pulse_done(W_DRAW, 1'b0, 3'd0);
    end
    checks++; if (cur_x !== 5'd0) begin errors++; $display("FAIL left_walk got %0d exp 0", cur_x); end
    mv_left = 1'b1; @(negedge clk); mv_left = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (col_req) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0 || cur_x !== 5'd0) begin errors++; $display("FAIL left_wall got req_cycles %0d x%0d exp 0 x0", seen, cur_x); end
    mv_rot = 1'b1; mv_left = 1'b1; @(negedge clk); mv_rot = 1'b0; mv_left = 1'b0;
    wait_req(W_COL, 5, found, cyc);
    checks++; if ({found, cand_rot, cand_x} !== {1'b1, 2'd1, 5'd0}) begin errors++; $display("FAIL rot_priority got req%b r%0d x%0d exp req1 r1 x0", found, cand_rot, cand_x); end
    pulse_done(W_COL, 1'b1, 3'd0);
    checks++; if ({col_req, cand_rot, cur_rot} !== {1'b0, 2'd0, 2'd0}) begin errors++; $display("FAIL rot_hit_restore got req%b cand_r%0d cur_r%0d exp 0 0 0", col_req, cand_rot, cur_rot); end
  endtask

  task automatic test_lines();
    bit found; int cyc; logic [5:0] y_exp;
    y_exp = 6'd1;
    for (int n = 0; n < 3; n++) begin
      mv_drop = 1'b1; @(negedge clk); mv_drop = 1'b0;
      wait_req(W_COL, 5, found, cyc);
      checks++; if ({found, cand_y} !== {1'b1, y_exp + 6'd1}) begin errors++; $display("FAIL drop_cand got req%b y%0d exp req1 y%0d", found, cand_y, y_exp + 6'd1); end
      pulse_done(W_COL, 1'b1, 3'd0);
      wait_req(W_LOCK, 5, found, cyc);
      checks++; if ({found, cand_y} !== {1'b1, y_exp}) begin errors++; $display("FAIL lock_req got req%b y%0d exp req1 y%0d", found, cand_y, y_exp); end
      pulse_done(W_LOCK, 1'b0, 3'd0);
      wait_req(W_LINE, 5, found, cyc);
      checks++; if (found !== 1'b1) begin errors++; $display("FAIL line_req got 0 exp 1"); end
      pulse_done(W_LINE, 1'b0, 3'd4);
      wait_req(W_COL, 10, found, cyc); pulse_done(W_COL, 1'b0, 3'd0);
      wait_req(W_DRAW, 10, found, cyc); pulse_done(W_DRAW, 1'b0, 3'd0);
      y_exp = 6'd0;
    end
    checks++; if ({lines_total, level} !== {16'd12, 4'd1}) begin errors++; $display("FAIL score got lines%0d lvl%0d exp lines12 lvl1", lines_total, level); end
    wait_req(W_COL, 60, found, cyc);
    checks++; if (!found || cyc != 15) begin errors++; $display("FAIL level1_tick got %0d exp 15", cyc); end
  endtask

  // Entered with the level-1 tick col_req pending.
  task automatic test_game_over();
    bit found; int cyc; int seen;
    pulse_done(W_COL, 1'b1, 3'd0);
    wait_req(W_LOCK, 5, found, cyc); pulse_done(W_LOCK, 1'b0, 3'd0);
    wait_req(W_LINE, 5, found, cyc); pulse_done(W_LINE, 1'b0, 3'd0);
    wait_req(W_COL, 10, found, cyc);
    pulse_done(W_COL, 1'b1, 3'd0);
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL over_flag got %b exp 1", game_over); end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (any_req()) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL over_quiet got %0d req cycles exp 0", seen); end
    go = 1'b1; repeat (2) @(negedge clk); go = 1'b0;
    wait_req(W_CLEAR, 10, found, cyc);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL restart_clear got 0 exp 1"); end
    pulse_done(W_CLEAR, 1'b0, 3'd0);
    checks++; if ({game_over, lines_total, level} !== 21'd0) begin errors++; $display("FAIL restart_zero got over%b lines%0d lvl%0d exp 0 0 0", game_over, lines_total, level); end
  endtask

  task automatic test_reset_mid();
    bit found; int cyc; int seen;
    wait_req(W_COL, 10, found, cyc); pulse_done(W_COL, 1'b0, 3'd0);
    wait_req(W_DRAW, 10, found, cyc);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL mid_draw_req got 0 exp 1"); end
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (any_req() !== 1'b0 || cur_x !== 5'd0) begin errors++; $display("FAIL mid_reset got req%b x%0d exp 0 0", any_req(), cur_x); end
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (any_req()) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_idle got %0d req cycles exp 0", seen); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_start();
    test_gravity();
    test_moves();
    test_lines();
    test_game_over();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tetris_game_seq.md
Name: tetris_game_seq

Overview:
- Parametrised game-step sequencer: the next generation of the board-level Tetris control FSM.
- Orders board clear, piece spawn, collision check, erase/draw, piece lock and line clear through req/done handshakes to sub-units (collision, draw_tetromino, lock, line-clear).
- Adds player moves, soft drop, game-over detection, line/level bookkeeping and level-scaled gravity, which the previous controller lacked.
- Sits at the top of the game datapath, above the VGA draw path.

Parameters:
- COLS, 10, board width in cells; anchor X range 0..COLS-1.
- ROWS, 20, board height in cells.
- XW, 5, anchor X width.
- YW, 6, anchor Y width.
- SPAWN_X, 4, anchor X at spawn.
- TICK_CYCLES, 25000000, gravity period at level 0, in clk cycles.
- TICK_DEC, 2000000, period reduction per level.
- MIN_TICK, 2500000, period floor.
- LEVEL_LINES, 10, lines per level.
- LFSR_SEED, 8'h01, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- go  in  1  start/restart button; acts on its falling edge.
- mv_left, mv_right, mv_rot, mv_drop  in  1 each  one-cycle move pulses.
- clear_req  out  1  board clear request.
- clear_done  in  1  board clear complete.
- col_req  out  1  collision check request.
- col_done  in  1  collision check complete.
- col_hit  in  1  candidate collides; valid with col_done.
- lock_req  out  1  lock request: write current piece into board RAM.
- lock_done  in  1  lock complete.
- line_req  out  1  line-clear request.
- line_done  in  1  line-clear complete.
- lines_cleared  in  3  rows removed, 0..4; valid with line_done.
- draw_req  out  1  draw request.
- draw_done  in  1  draw complete.
- draw_clear  out  1  1 = erase, 0 = paint.
- cand_x  out  XW  candidate anchor X, driven to collision and draw.
- cand_y  out  YW  candidate anchor Y.
- cand_piece  out  3  candidate piece, 0..6.
- cand_rot  out  2  candidate rotation.
- cur_x  out  XW  committed anchor X.
- cur_y  out  YW  committed anchor Y.
- cur_piece  out  3  committed piece.
- cur_rot  out  2  committed rotation.
- lines_total  out  16  total lines cleared.
- level  out  4  current level.
- game_over  out  1  game-over flag.

Behaviour:
- Reset values: state IDLE; all req outputs, draw_clear and game_over = 0; cur_*, cand_*, lines_total, level and the gravity counter = 0; LFSR = LFSR_SEED.
- Reset applies mid-handshake: all reqs drop on the next edge.
- Handshake:
  - req rises on state entry and is held until a done pulse is sampled.
  - cand_*/draw_clear are stable while req = 1.
  - req = 0 the cycle after done; done while req = 0 is ignored.
  - At most one req is high at a time.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4; advances every cycle out of reset. Spawn piece = lfsr[2:0], with 7 mapped to 3.
- IDLE: go seen high then low -> CLEAR.
- CLEAR: clear_req; on clear_done -> SPAWN. Also zeroes lines_total, level and game_over.
- SPAWN (1 cycle): cand = (SPAWN_X, 0, LFSR piece, rot 0) -> SPAWN_CHK.
- SPAWN_CHK: col_req. On done: hit -> OVER; no hit -> DRAW.
- DRAW: draw_req, draw_clear = 0. On done: cur <= cand, gravity counter <= 0 on a down step or spawn -> WAIT.
- WAIT:
  - Gravity counter increments each cycle.
  - Per-cycle event priority: tick (counter = period-1) or mv_drop > mv_rot > mv_left > mv_right. Lower-priority pulses in the same cycle are dropped.
  - Move pulses are sampled only in WAIT.
  - Down: cand_y = cur_y+1.
  - Rot: cand_rot = cur_rot+1, wrapping 3->0.
  - Left at cur_x = 0, or right at cur_x = COLS-1: ignored, stay WAIT, no col_req.
  - Otherwise go to CHECK with cand latched.
- CHECK: col_req.
  - No hit -> ERASE.
  - Hit on a down step -> LOCK.
  - Hit on lateral/rot -> WAIT; cand restored to cur; counter not reset.
- ERASE: draw_req with draw_clear = 1 at cur_* -> DRAW on done.
- LOCK: lock_req at cur_* -> LINES.
- LINES: line_req. On line_done:
  - lines_total += lines_cleared, saturating at 16'hFFFF.
  - An internal level counter adds the lines; each time it reaches LEVEL_LINES, subtract LEVEL_LINES and increment level, saturating at 15.
  - Then -> SPAWN.
- Gravity period = max(TICK_CYCLES - level*TICK_DEC, MIN_TICK); 32-bit arithmetic, no underflow.
- OVER: game_over = 1, no reqs; a go falling edge -> CLEAR.

Test Plan:
- Reset, no go -> state IDLE, all reqs 0, level 0, lines_total 0, game_over 0, cur_* 0.
- go 1 for 3 cycles then 0; clear_done after 5 cycles; col_hit = 0 -> col_req with cand_x = 4, cand_y = 0, rot 0; then draw_req with draw_clear = 0; cur_x = 4 after draw_done.
- TICK_CYCLES = 20, game in WAIT, no moves -> col_req exactly 20 cycles after WAIT entry with cand_y = cur_y+1; erase (draw_clear = 1), then draw; cur_y increments.
- cur_x = 0, mv_left pulse -> no col_req, remains WAIT. mv_rot and mv_left in the same cycle -> only rotation checked, cand_rot = cur_rot+1.
- mv_drop, col_hit = 1 -> lock_req, then line_req. lines_cleared = 4 three times (LEVEL_LINES = 10) -> lines_total 12, level 1, next tick period TICK_CYCLES - TICK_DEC.
- Spawn check col_hit = 1 -> game_over = 1, no further reqs. go press/release -> clear_req, game_over 0.
- Assert reset_n = 0 while draw_req = 1 -> next edge all reqs 0, state IDLE.
